// File: rtl/spi_slave_tx_fifo.sv
// spi_slave_tx_fifo: SPI slave transmitter with an internal TX FIFO.
// SCK and CS are oversampled in the clk domain, and all four CPOL/CPHA modes
// are supported. A word leaves the FIFO only when its first bit is captured.
// Optional build macro SPI_SLAVE_TX_LSB_FIRST_EN adds lsb_first_i.
module spi_slave_tx_fifo #(
    parameter int DATA_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          spi_cs_i,
    input  logic                          spi_sck_i,
    output logic                          spi_sdo_o,
    output logic                          spi_sdo_oe_o,
    input  logic                          cpol_i,
    input  logic                          cpha_i,
`ifdef SPI_SLAVE_TX_LSB_FIRST_EN
    input  logic                          lsb_first_i,
`endif
    input  logic [DATA_WIDTH-1:0]         tx_data_i,
    input  logic                          tx_valid_i,
    output logic                          tx_ready_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          word_done_o,
    output logic                          underrun_o,
    output logic                          busy_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_SHIFT} state_t;

    // ---------------- synchronisers and edge detection ----------------
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d, cs_sync_q, cs_sync_d;
    logic                   sck_hist_q, sck_hist_d, cs_hist_q, cs_hist_d;
    logic                   sck_s, cs_s, sck_edge, lead_edge, trail_edge;
    logic                   cap_edge, shf_edge, cs_fall, cs_rise;
    logic                   cpol_q, cpol_d, cpha_q, cpha_d;

    // Next values of the synchroniser chains and edge-history flops.
    always_comb begin
        sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], spi_sck_i};
        cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_i};
        sck_hist_d = sck_sync_q[SYNC_STAGES-1];
        cs_hist_d  = cs_sync_q[SYNC_STAGES-1];
    end

    // Synchroniser registers; CS resets to its inactive (high) level.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q <= '0;
            cs_sync_q  <= '1;
            sck_hist_q <= 1'b0;
            cs_hist_q  <= 1'b1;
        end else begin
            sck_sync_q <= sck_sync_d;
            cs_sync_q  <= cs_sync_d;
            sck_hist_q <= sck_hist_d;
            cs_hist_q  <= cs_hist_d;
        end
    end

    assign sck_s      = sck_sync_q[SYNC_STAGES-1];
    assign cs_s       = cs_sync_q[SYNC_STAGES-1];
    assign sck_edge   = sck_s ^ sck_hist_q;
    assign lead_edge  = sck_edge & (sck_hist_q == cpol_q);  // leaving idle level
    assign trail_edge = sck_edge & (sck_s == cpol_q);       // returning to idle
    assign cap_edge   = cpha_q ? trail_edge : lead_edge;
    assign shf_edge   = cpha_q ? lead_edge : trail_edge;
    assign cs_fall    = cs_hist_q & ~cs_s;
    assign cs_rise    = ~cs_hist_q & cs_s;

    // ---------------- TX FIFO ----------------
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  ready_q, ready_d;
    logic                  push, pop, fifo_empty;

    assign push       = tx_valid_i & ready_q;
    assign fifo_empty = (level_q == '0);

    // Pointer and occupancy bookkeeping; ready is precomputed from next level.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
        ready_d  = (level_d < FULL_LVL);
    end

    // FIFO storage write port.
    // NOTE: the storage array is not reset; the pointers and level define
    // what is valid, so clearing them is enough to empty the FIFO.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= tx_data_i;
    end

    // FIFO pointer, level and ready registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ready_q  <= ready_d;
        end
    end

    // ---------------- shifter FSM ----------------
    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, shifted;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  first_cap_q, first_cap_d, loaded_q, loaded_d;
    logic                  word_done_q, word_done_d, underrun_q, underrun_d;
    logic                  load, out_bit;

`ifdef SPI_SLAVE_TX_LSB_FIRST_EN
    logic lsb_q, lsb_d;
    assign shifted = lsb_q ? {1'b0, shift_q[DATA_WIDTH-1:1]} : {shift_q[DATA_WIDTH-2:0], 1'b0};
    assign out_bit = lsb_q ? shift_q[0] : shift_q[DATA_WIDTH-1];

    // Bit-order selection latched at frame start.
    always_comb begin
        lsb_d = lsb_q;
        if (state_q == S_IDLE && cs_fall) lsb_d = lsb_first_i;
    end

    // Bit-order register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lsb_q <= 1'b0;
        else        lsb_q <= lsb_d;
    end
`else
    assign shifted = {shift_q[DATA_WIDTH-2:0], 1'b0};
    assign out_bit = shift_q[DATA_WIDTH-1];
`endif

    // Next-state, shift/load, deferred pop and status pulses.
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        first_cap_d = first_cap_q;
        loaded_d    = loaded_q;
        cpol_d      = cpol_q;
        cpha_d      = cpha_q;
        word_done_d = 1'b0;
        underrun_d  = 1'b0;
        pop         = 1'b0;
        load        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cs_fall) begin
                    cpol_d  = cpol_i;
                    cpha_d  = cpha_i;
                    load    = 1'b1;
                    state_d = cpha_i ? S_ARM : S_SHIFT;
                end
            end
            S_ARM: begin
                // First leading edge only presents bit 0; nothing shifts.
                if (lead_edge) state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (shf_edge) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        load = 1'b1;
                    end else begin
                        shift_d   = shifted;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (cap_edge) begin
                    if (first_cap_q) begin
                        pop         = loaded_q;
                        underrun_d  = ~loaded_q;
                        first_cap_d = 1'b0;
                    end
                    if (bit_cnt_q == LAST_BIT) word_done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Peek the FIFO head; an empty FIFO presents zeros.
        if (load) begin
            shift_d     = fifo_empty ? '0 : mem[rd_ptr_q];
            loaded_d    = ~fifo_empty;
            bit_cnt_d   = '0;
            first_cap_d = 1'b1;
        end
        // CS release aborts the frame from any state; an unpopped word stays.
        if (cs_rise) begin
            state_d     = S_IDLE;
            bit_cnt_d   = '0;
            first_cap_d = 1'b0;
            loaded_d    = 1'b0;
            pop         = 1'b0;
            word_done_d = 1'b0;
            underrun_d  = 1'b0;
        end
    end

    // FSM, shifter and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            first_cap_q <= 1'b0;
            loaded_q    <= 1'b0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            word_done_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            first_cap_q <= first_cap_d;
            loaded_q    <= loaded_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            word_done_q <= word_done_d;
            underrun_q  <= underrun_d;
        end
    end

    assign spi_sdo_o    = (state_q != S_IDLE) & out_bit;
    assign spi_sdo_oe_o = ~cs_s;
    assign tx_ready_o   = ready_q;
    assign fifo_level_o = level_q;
    assign word_done_o  = word_done_q;
    assign underrun_o   = underrun_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_slave_tx_fifo.sv
// Directed testbench for spi_slave_tx_fifo (default build, MSB first).
// An SPI master model drives SCK/CS with 8-clk half periods and samples SDO
// just before each capture edge.
module tb_spi_slave_tx_fifo;

    localparam int HALF = 8;

    logic        clk, rst_n;
    logic        spi_cs_i, spi_sck_i, spi_sdo_o, spi_sdo_oe_o;
    logic        cpol_i, cpha_i;
    logic [31:0] tx_data_i;
    logic        tx_valid_i, tx_ready_o;
    logic [2:0]  fifo_level_o;
    logic        word_done_o, underrun_o, busy_o;

    int          n_tests, n_fail, wd_cnt, ur_cnt, wd0, ur0;
    logic        m_cpol, m_cpha, got_ready;
    logic [63:0] rx, rx_a;

    spi_slave_tx_fifo #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_cs_i     (spi_cs_i),
        .spi_sck_i    (spi_sck_i),
        .spi_sdo_o    (spi_sdo_o),
        .spi_sdo_oe_o (spi_sdo_oe_o),
        .cpol_i       (cpol_i),
        .cpha_i       (cpha_i),
        .tx_data_i    (tx_data_i),
        .tx_valid_i   (tx_valid_i),
        .tx_ready_o   (tx_ready_o),
        .fifo_level_o (fifo_level_o),
        .word_done_o  (word_done_o),
        .underrun_o   (underrun_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (word_done_o) wd_cnt++;
        if (underrun_o)  ur_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d);
        tx_data_i  = d;
        tx_valid_i = 1'b1;
        @(negedge clk);
        tx_valid_i = 1'b0;
    endtask

    task automatic cs_low(input logic pol, input logic pha);
        cpol_i = pol; cpha_i = pha; m_cpol = pol; m_cpha = pha;
        spi_sck_i = pol;
        repeat (HALF) @(negedge clk);
        spi_cs_i = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_high();
        spi_cs_i = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic clk_bits(input int n, output logic [63:0] r);
        r = '0;
        for (int i = 0; i < n; i++) begin
            if (!m_cpha) r = {r[62:0], spi_sdo_o};
            spi_sck_i = ~m_cpol;
            repeat (HALF) @(negedge clk);
            if (m_cpha) r = {r[62:0], spi_sdo_o};
            spi_sck_i = m_cpol;
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic snap();
        wd0 = wd_cnt;
        ur0 = ur_cnt;
    endtask

    initial begin
        n_tests = 0; n_fail = 0; wd_cnt = 0; ur_cnt = 0;
        rst_n = 1'b0; spi_cs_i = 1'b1; spi_sck_i = 1'b0;
        cpol_i = 1'b0; cpha_i = 1'b0; m_cpol = 1'b0; m_cpha = 1'b0;
        tx_data_i = '0; tx_valid_i = 1'b0; got_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_sdo", spi_sdo_o, 0);
        check("rst_oe", spi_sdo_oe_o, 0);
        check("rst_ready", tx_ready_o, 1);
        check("rst_level", fifo_level_o, 0);
        check("rst_wd", word_done_o, 0);
        check("rst_ur", underrun_o, 0);
        check("rst_busy", busy_o, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Mode 0, single word; level drops at the first capture.
        snap();
        push(32'hA5A5_0F0F);
        @(negedge clk);
        check("m0_level_pushed", fifo_level_o, 1);
        cs_low(1'b0, 1'b0);
        check("m0_busy", busy_o, 1);
        check("m0_oe", spi_sdo_oe_o, 1);
        check("m0_level_peek", fifo_level_o, 1);
        clk_bits(1, rx_a);
        check("m0_level_after_bit0", fifo_level_o, 0);
        clk_bits(31, rx);
        check("m0_rx", {32'h0, rx_a[0], rx[30:0]}, 64'hA5A5_0F0F);
        check("m0_wd", 64'(wd_cnt - wd0), 1);
        check("m0_ur", 64'(ur_cnt - ur0), 0);
        cs_high();
        check("m0_idle_busy", busy_o, 0);
        check("m0_idle_oe", spi_sdo_oe_o, 0);
        check("m0_level_end", fifo_level_o, 0);

        // Mode 3, two back-to-back words in one frame.
        snap();
        push(32'h1234_5678);
        push(32'hDEAD_BEEF);
        @(negedge clk);
        check("m3_level", fifo_level_o, 2);
        cs_low(1'b1, 1'b1);
        clk_bits(64, rx);
        check("m3_rx", rx, 64'h1234_5678_DEAD_BEEF);
        check("m3_wd", 64'(wd_cnt - wd0), 2);
        check("m3_level_end", fifo_level_o, 0);
        cs_high();

        // Mode 1 with an empty FIFO: zeros and one underrun.
        snap();
        cs_low(1'b0, 1'b1);
        clk_bits(32, rx);
        check("m1_rx", rx, 64'h0);
        check("m1_ur", 64'(ur_cnt - ur0), 1);
        check("m1_wd", 64'(wd_cnt - wd0), 1);
        check("m1_level", fifo_level_o, 0);
        cs_high();

        // Mode 0, abort after 12 bits; next frame sends the next word.
        snap();
        push(32'hCAFE_F00D);
        cs_low(1'b0, 1'b0);
        clk_bits(12, rx);
        cs_high();
        check("abort_rx12", rx, 64'hCAF);
        check("abort_wd", 64'(wd_cnt - wd0), 0);
        check("abort_level", fifo_level_o, 0);
        check("abort_busy", busy_o, 0);
        push(32'h3C3C_3C3C);
        cs_low(1'b0, 1'b0);
        clk_bits(32, rx);
        cs_high();
        check("abort_next_rx", rx, 64'h3C3C_3C3C);
        check("abort_next_wd", 64'(wd_cnt - wd0), 1);

        // Full FIFO back-pressure; the 5th word enters after the first pop.
        snap();
        push(32'h1111_1111);
        push(32'h2222_2222);
        push(32'h3333_3333);
        push(32'h4444_4444);
        check("full_level", fifo_level_o, 4);
        check("full_ready", tx_ready_o, 0);
        tx_data_i  = 32'h5555_5555;
        tx_valid_i = 1'b1;
        repeat (10) @(negedge clk);
        check("full_hold_level", fifo_level_o, 4);
        check("full_hold_ready", tx_ready_o, 0);
        cs_low(1'b0, 1'b0);
        check("full_peek_ready", tx_ready_o, 0);
        fork
            clk_bits(32, rx);
            begin
                for (int k = 0; k < 200; k++) begin
                    if (tx_ready_o) begin
                        got_ready = 1'b1;
                        break;
                    end
                    @(negedge clk);
                end
                @(negedge clk);
                tx_valid_i = 1'b0;
            end
        join
        check("full_got_ready", got_ready, 1);
        check("full_rx", rx, 64'h1111_1111);
        check("full_level_end", fifo_level_o, 4);
        check("full_wd", 64'(wd_cnt - wd0), 1);
        clk_bits(64, rx);
        check("full_rx_next", rx, 64'h2222_2222_3333_3333);
        cs_high();
        check("full_level_2", fifo_level_o, 2);

        // Reset mid-word, then a clean frame after release.
        snap();
        cs_low(1'b0, 1'b0);
        clk_bits(17, rx);
        spi_cs_i = 1'b1;
        rst_n    = 1'b0;
        #1;
        check("midrst_sdo", spi_sdo_o, 0);
        check("midrst_oe", spi_sdo_oe_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_level", fifo_level_o, 0);
        check("midrst_ready", tx_ready_o, 1);
        check("midrst_wd", word_done_o, 0);
        check("midrst_ur", underrun_o, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        snap();
        push(32'h0F1E_2D3C);
        cs_low(1'b0, 1'b0);
        clk_bits(32, rx);
        cs_high();
        check("postrst_rx", rx, 64'h0F1E_2D3C);
        check("postrst_wd", 64'(wd_cnt - wd0), 1);
        check("postrst_ur", 64'(ur_cnt - ur0), 0);
        check("postrst_level", fifo_level_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_tx_fifo.md
Name: spi_slave_tx_fifo

Overview:
- Parametrised SPI slave transmitter: next generation of the SoC's 32-bit negedge-clocked SPI sender.
- Runs entirely in the system clock domain; SCK and CS are oversampled through synchronisers.
- Supports all four CPOL/CPHA modes and configurable word width.
- Feeds back-to-back words from an internal TX FIFO and reports underrun instead of silently sending stale data.

Parameters:
- DATA_WIDTH, 32: bits per SPI word; legal range 8..64.
- FIFO_DEPTH, 4: TX FIFO entries; power of two, ≥2.
- SYNC_STAGES, 2: synchroniser flops on spi_sck_i and spi_cs_i; ≥2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- spi_cs_i  in  1  chip select, active-low, asynchronous to clk
- spi_sck_i  in  1  SPI clock, asynchronous to clk
- spi_sdo_o  out  1  serial data out
- spi_sdo_oe_o  out  1  pad output enable; 1 while the synchronised CS is low
- cpol_i  in  1  SCK idle level; sampled only in IDLE
- cpha_i  in  1  0: master captures on leading edge; 1: captures on trailing edge; sampled only in IDLE
- tx_data_i  in  DATA_WIDTH  word to enqueue
- tx_valid_i  in  1  enqueue request
- tx_ready_o  out  1  FIFO not full
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- word_done_o  out  1  1-cycle pulse when the last bit of a word is captured
- underrun_o  out  1  1-cycle pulse when the first capture of a word finds no FIFO data loaded
- busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset values: spi_sdo_o=0, spi_sdo_oe_o=0, tx_ready_o=1, fifo_level_o=0, word_done_o=0, underrun_o=0, busy_o=0, FSM=IDLE. FIFO is emptied; shift register, bit_cnt and all flags are cleared.
- Synchronisation: SCK and CS each pass through SYNC_STAGES flops, plus one history flop for edge detection. Edge events are therefore seen SYNC_STAGES+1 clk after the pin changes.
- Timing requirement: SCK high and low phases are each ≥ SYNC_STAGES+3 clk.
- Edge classification: leading edge = SCK leaving cpol_i; trailing edge = SCK returning to cpol_i.
  - capture edge = leading if cpha=0, trailing if cpha=1.
  - shift edge = the other edge.
- FIFO push: tx_valid_i & tx_ready_o. tx_ready_o = (level < FIFO_DEPTH).
- Load: the shift register takes the FIFO head word without popping (peek).
  - loaded_q = FIFO non-empty at that cycle.
  - If the FIFO is empty, the shift register loads all-zeros.
  - A push in the same cycle as a load is not seen by that load.
- FSM states:
  - IDLE: sdo=0. On the synchronised CS falling edge: latch cpol/cpha, load, bit_cnt=0, first_cap_q=1. Go to ARM if cpha=1, else SHIFT.
  - ARM (cpha=1 only): the first leading edge presents bit 0 without shifting; go to SHIFT.
  - SHIFT, on a shift edge:
    - bit_cnt==DATA_WIDTH-1: load, bit_cnt=0, first_cap_q=1.
    - otherwise: shift toward the output bit; bit_cnt+1.
  - SHIFT, on a capture edge:
    - If first_cap_q: pop FIFO if loaded_q, else pulse underrun_o. Clear first_cap_q.
    - If bit_cnt==DATA_WIDTH-1: pulse word_done_o.
- Output: spi_sdo_o = shift_reg[DATA_WIDTH-1] (MSB first).
- Deferred pop: a word leaves the FIFO only when its first bit is actually captured. A trailing-edge reload at end of frame therefore never loses data.
- CS deasserted (synchronised rising edge) in any state: return to IDLE next clk; sdo=0, oe=0, bit_cnt=0.
  - A word that was popped but is incomplete is discarded; no word_done_o.
  - A word that was peeked but not popped stays in the FIFO.
- Simultaneous push and pop: level is unchanged; a full FIFO accepts no push that cycle even if it pops.
- fifo_level_o, tx_ready_o: registered; they update the clk after the push or pop.

Optional Feature:
- Macro SPI_SLAVE_TX_LSB_FIRST_EN.
  - Defined: adds input lsb_first_i (1 bit, sampled in IDLE). When 1, spi_sdo_o = shift_reg[0] and the register shifts right; the word_done_o and underrun_o rules are unchanged.
  - Undefined: port absent, MSB first only.

Test Plan:
- Mode 0, push 0xA5A5_0F0F, 32 SCK cycles → master captures 0xA5A50F0F; one word_done_o pulse; fifo_level_o goes 1→0 at the first leading edge.
- Mode 3, push 0x1234_5678 and 0xDEAD_BEEF, 64 SCK cycles in one CS frame → both words received back-to-back with no gap bit; two word_done_o pulses; FIFO ends empty.
- Mode 1, FIFO empty at CS fall, 32 SCK cycles → 0x00000000 received; one underrun_o pulse at the first trailing edge; fifo_level_o stays 0.
- Mode 0, push 0xCAFE_F00D, raise CS after 12 bits → returns to IDLE; no word_done_o; FIFO empty; the next frame sends the next word or underruns.
- Push 4 words, hold tx_valid_i with a 5th → tx_ready_o=0 and fifo_level_o=4; the 5th word is accepted only after the first capture pops a word.
- Assert rst_n=0 mid-word (bit 17) → all outputs return to reset values immediately; a frame after release transmits the next pushed word from bit 0.
